micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
- Parametrised microprogrammed control sequencer; next generation of the fixed 76-word control store.
- Holds a writable control store and a microprogram counter (upc), and drives the registered microinstruction (mir) to the datapath.
- Supports next-field sequencing, opcode dispatch, condition-selected branching, register-select substitution and micro-subroutine call/return.
- Sits between the instruction register/flags and all datapath control inputs.

Parameters:
- ADDR_W, 9: micro-address and next-field width.
- CTRL_W, 27: datapath control field width; mir width = ADDR_W+CTRL_W.
- DEPTH, 76: control store words; must be <= 2**ADDR_W.
- NUM_COND, 4: condition inputs; CSEL_W = max(1, clog2(NUM_COND)).
- SEL_W, 4: substituted register-select width.
- SUB_LSB, 3: LSB of the substituted field within ctrl.
- SEL_BASE, 3: select code for operand register 1.
- NUM_REGS, 8: operand codes 1..NUM_REGS are valid.
- STACK_DEPTH, 4: return stack entries.

Ports:
- clk, in, 1: clock; all state updates on the falling edge.
- rst_n, in, 1: asynchronous active-low reset.
- en, in, 1: sequencing enable.
- ir, in, ADDR_W: opcode/operand from the instruction register.
- cond, in, NUM_COND: condition flags (N, lsb, ...).
- prog_we, in, 1: control-store write strobe.
- prog_addr, in, ADDR_W: write address.
- prog_data, in, ADDR_W+3+CSEL_W+1+CTRL_W: ROM word.
- mir, out, ADDR_W+CTRL_W: current microinstruction {next, ctrl}.
- upc, out, ADDR_W: address of the current mir.
- halted, out, 1: HALT executed.
- seq_err, out, 1: sticky error flag (illegal dispatch, stack overflow or underflow).

Behaviour:
- ROM word layout: {next[ADDR_W], seq[2:0], csel[CSEL_W], sub, ctrl[CTRL_W]}. Only {next, ctrl'} drives mir.
- Reset (async, rst_n=0): mir=0, upc=0, halted=0, seq_err=0, stack pointer=0. Control store contents are retained.
- The all-zero mir after reset means NEXT to 0, so the first enabled falling edge loads ROM[0].
- Each falling edge with en=1 and halted=0:
  - Compute target from the current mir's seq/csel (held internally alongside mir).
  - mir <= subst(ROM[target]); upc <= target. Latency is one falling edge per microinstruction.
- en=0 or halted=1: all state holds.
- seq decode:
  - 000 NEXT: target = next.
  - 001 DISPATCH: target = ir. If ir >= DEPTH: target = 0 and seq_err <= 1.
  - 010 BRANCH: target = cond[csel] ? next : upc+1.
  - 011 CALL: push upc+1; target = next.
  - 100 RETURN: pop; target = popped address.
  - 101 HALT: halted <= 1, mir/upc hold.
  - 110 and 111: treated as NEXT.
- csel >= NUM_COND: condition reads 0.
- Substitution (sub=1): ctrl[SUB_LSB+SEL_W-1:SUB_LSB] is replaced by:
  - ir - 1 + SEL_BASE, when 1 <= ir <= NUM_REGS (truncated to SEL_W);
  - 0 otherwise.
  - Decode uses ir sampled at the same edge. With sub=0, ctrl passes unchanged.
- upc+1 wraps modulo 2**ADDR_W. A wrap or next >= DEPTH fetches an all-zero word (NEXT 0).
- Return stack:
  - Push when full: push is dropped, seq_err <= 1, branch still taken.
  - Pop when empty: target = 0, seq_err <= 1.
- Program port: at a falling edge with prog_we=1 and prog_addr < DEPTH, ROM[prog_addr] <= prog_data. Out-of-range writes are ignored.
- Same-edge write to the address being fetched returns the old word (read-before-write).
- seq_err is cleared only by reset.

Optional Feature:
- Macro: MSEQ_CALL_STACK_EN.
- Defined: return stack present, CALL/RETURN as above.
- Undefined: no stack storage.
  - CALL behaves as NEXT.
  - RETURN targets address 0 (fetch entry) and never sets seq_err.
  - Stack over/underflow conditions do not exist.

Test Plan:
- Reset mid-run at upc=5 -> mir=0, upc=0 immediately. After release, first edge loads ROM[0], upc=0.
- Program NEXT chain 0->1->2, then DISPATCH at 3 with ir=20 -> upc sequence 0,1,2,3,20. With ir=100 (DEPTH 76) -> upc=0, seq_err=1.
- BRANCH at 63 with next=66, csel=1: cond[1]=0 -> upc 64; cond[1]=1 -> upc 66.
- Word 13 with sub=1, ctrl bits[6:3]=0: ir=1 -> field 3; ir=8 -> field 10; ir=9 -> field 0. Other ctrl bits unchanged.
- MSEQ_CALL_STACK_EN defined: CALL at 10 (next=40), RETURN at 40 -> upc 10,40,11. Five nested CALLs -> seq_err=1 on the 5th. RETURN on empty stack -> upc 0.
- HALT at 75 -> halted=1, upc stays 75 across 10 edges with en=1. prog_we to addr 75 on the same edge as the fetch of 75 -> mir holds the old word.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogrammed control sequencer: writable control store, upc and registered mir, all updated on the falling clock edge.
// Optional return stack for CALL/RETURN is enabled by defining MSEQ_CALL_STACK_EN.
module micro_sequencer #(
  parameter int ADDR_W      = 9,
  parameter int CTRL_W      = 27,
  parameter int DEPTH       = 76,
  parameter int NUM_COND    = 4,
  parameter int SEL_W       = 4,
  parameter int SUB_LSB     = 3,
  parameter int SEL_BASE    = 3,
  parameter int NUM_REGS    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [ADDR_W-1:0]         ir,
  input  logic [NUM_COND-1:0]       cond,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [ADDR_W+3+((NUM_COND > 1) ? $clog2(NUM_COND) : 1)+CTRL_W:0] prog_data,
  output logic [ADDR_W+CTRL_W-1:0]  mir,
  output logic [ADDR_W-1:0]         upc,
  output logic                      halted,
  output logic                      seq_err
);

  localparam int CSEL_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1;
  localparam int ROM_W  = ADDR_W + 3 + CSEL_W + 1 + CTRL_W;
  localparam int MIR_W  = ADDR_W + CTRL_W;
  localparam int RA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  localparam logic [2:0] SEQ_NEXT     = 3'b000;
  localparam logic [2:0] SEQ_DISPATCH = 3'b001;
  localparam logic [2:0] SEQ_BRANCH   = 3'b010;
  localparam logic [2:0] SEQ_CALL     = 3'b011;
  localparam logic [2:0] SEQ_RETURN   = 3'b100;
  localparam logic [2:0] SEQ_HALT     = 3'b101;

  logic [ROM_W-1:0]  rom [DEPTH];

  logic [MIR_W-1:0]  mir_reg, mir_next;
  logic [ADDR_W-1:0] upc_reg, target;
  logic [2:0]        seq_reg;
  logic [CSEL_W-1:0] csel_reg;
  logic              halted_reg, err_reg;

  logic              step, halt_set, err_set, zero_word, cond_bit, sel_ok;
  logic [ADDR_W:0]   upc_inc;
  logic [ADDR_W-1:0] next_field;
  logic [ROM_W-1:0]  fetch_word;
  logic [ADDR_W-1:0] fw_next;
  logic [2:0]        fw_seq;
  logic [CSEL_W-1:0] fw_csel;
  logic              fw_sub;
  logic [CTRL_W-1:0] fw_ctrl, ctrl_sub;
  logic [SEL_W-1:0]  sel_val;

`ifdef MSEQ_CALL_STACK_EN
  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int ST_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp_reg, sp_m1;
  logic              push_req, pop_req;

  assign sp_m1 = sp_reg - SP_W'(1);
`endif

  assign step       = en && !halted_reg;
  assign next_field = mir_reg[MIR_W-1 -: ADDR_W];
  assign upc_inc    = {1'b0, upc_reg} + (ADDR_W+1)'(1);
  assign cond_bit   = (32'(csel_reg) < NUM_COND) ? cond[csel_reg] : 1'b0;

  always_comb begin
    target    = next_field;
    zero_word = 1'b0;
    halt_set  = 1'b0;
    err_set   = 1'b0;
`ifdef MSEQ_CALL_STACK_EN
    push_req  = 1'b0;
    pop_req   = 1'b0;
`endif
    case (seq_reg)
      SEQ_DISPATCH: begin
        if ({1'b0, ir} >= DEPTH_L) begin
          target  = '0;
          err_set = 1'b1;
        end else begin
          target  = ir;
        end
      end
      SEQ_BRANCH: begin
        // Fall-through past the top of the address space fetches a blank word.
        if (!cond_bit) begin
          target    = upc_inc[ADDR_W-1:0];
          zero_word = upc_inc[ADDR_W];
        end
      end
`ifdef MSEQ_CALL_STACK_EN
      SEQ_CALL: begin
        if (sp_reg == SP_FULL) err_set  = 1'b1;
        else                   push_req = 1'b1;
      end
      SEQ_RETURN: begin
        if (sp_reg == '0) begin
          target  = '0;
          err_set = 1'b1;
        end else begin
          target  = stack_mem[sp_m1[ST_W-1:0]];
          pop_req = 1'b1;
        end
      end
`else
      SEQ_CALL:   target = next_field;
      SEQ_RETURN: target = '0;
`endif
      SEQ_HALT:   halt_set = 1'b1;
      default:    target = next_field;
    endcase
  end

  // Asynchronous read; the falling-edge mir register provides the pipeline stage.
  assign fetch_word = (zero_word || ({1'b0, target} >= DEPTH_L)) ? '0 : rom[target[RA_W-1:0]];
  assign fw_next    = fetch_word[ROM_W-1 -: ADDR_W];
  assign fw_seq     = fetch_word[CTRL_W+CSEL_W+1 +: 3];
  assign fw_csel    = fetch_word[CTRL_W+1 +: CSEL_W];
  assign fw_sub     = fetch_word[CTRL_W];
  assign fw_ctrl    = fetch_word[CTRL_W-1:0];

  assign sel_ok  = (ir != '0) && (32'(ir) <= 32'(NUM_REGS));
  assign sel_val = sel_ok ? (SEL_W'(ir) + SEL_W'(SEL_BASE) - SEL_W'(1)) : '0;

  always_comb begin
    ctrl_sub = fw_ctrl;
    if (fw_sub) ctrl_sub[SUB_LSB +: SEL_W] = sel_val;
    mir_next = {fw_next, ctrl_sub};
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mir_reg    <= '0;
      upc_reg    <= '0;
      seq_reg    <= SEQ_NEXT;
      csel_reg   <= '0;
      halted_reg <= 1'b0;
      err_reg    <= 1'b0;
    end else if (step) begin
      if (err_set) err_reg <= 1'b1;
      if (halt_set) begin
        halted_reg <= 1'b1;
      end else begin
        mir_reg  <= mir_next;
        upc_reg  <= target;
        seq_reg  <= fw_seq;
        csel_reg <= fw_csel;
      end
    end
  end

  // Control store is deliberately outside reset so a loaded microprogram survives it.
  always_ff @(negedge clk) begin
    if (prog_we && ({1'b0, prog_addr} < DEPTH_L))
      rom[prog_addr[RA_W-1:0]] <= prog_data;
  end

`ifdef MSEQ_CALL_STACK_EN
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_reg <= '0;
    end else if (step) begin
      if (push_req)     sp_reg <= sp_reg + SP_W'(1);
      else if (pop_req) sp_reg <= sp_m1;
    end
  end

  always_ff @(negedge clk) begin
    if (step && push_req) stack_mem[sp_reg[ST_W-1:0]] <= upc_inc[ADDR_W-1:0];
  end
`endif

  assign mir     = mir_reg;
  assign upc     = upc_reg;
  assign halted  = halted_reg;
  assign seq_err = err_reg;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: loads a small microprogram and checks sequencing, substitution, stack and halt.
// Expectations for CALL/RETURN follow MSEQ_CALL_STACK_EN as built.
module tb_micro_sequencer;

  localparam logic [2:0] NX = 3'd0, DS = 3'd1, BR = 3'd2, CL = 3'd3, RT = 3'd4, HT = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n, en, prog_we;
  logic [8:0]  ir, prog_addr;
  logic [3:0]  cond;
  logic [41:0] prog_data;
  logic [35:0] mir;
  logic [8:0]  upc;
  logic        halted, seq_err;

  int total = 0;
  int bad   = 0;

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ir(ir), .cond(cond),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .mir(mir), .upc(upc), .halted(halted), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] w(input logic [8:0] nx, input logic [2:0] sq,
                                    input logic [1:0] cs, input logic sb, input logic [26:0] ct);
    return {nx, sq, cs, sb, ct};
  endfunction

  function automatic logic [26:0] ctl(input int i);
    return 27'h100000 | 27'(i);
  endfunction

  function automatic logic [35:0] mm(input logic [8:0] nx, input logic [26:0] ct);
    return {nx, ct};
  endfunction

  function automatic logic [41:0] prog_word(input int i);
    if (i >= 30 && i <= 34) return w(9'(i + 1), CL, 2'd0, 1'b0, ctl(i));
    case (i)
      0:  return w(9'd1,   NX, 2'd0, 1'b0, ctl(0));
      1:  return w(9'd2,   NX, 2'd0, 1'b0, ctl(1));
      2:  return w(9'd3,   NX, 2'd0, 1'b0, ctl(2));
      3:  return w(9'd0,   DS, 2'd0, 1'b0, ctl(3));
      5:  return w(9'd5,   NX, 2'd0, 1'b0, ctl(5));
      10: return w(9'd40,  CL, 2'd0, 1'b0, ctl(10));
      11: return w(9'd11,  NX, 2'd0, 1'b0, ctl(11));
      13: return w(9'd13,  NX, 2'd0, 1'b1, 27'h7FFFF87);
      20: return w(9'd63,  NX, 2'd0, 1'b0, ctl(20));
      21: return w(9'd100, NX, 2'd0, 1'b0, ctl(21));
      35: return w(9'd35,  NX, 2'd0, 1'b0, ctl(35));
      40: return w(9'd0,   RT, 2'd0, 1'b0, ctl(40));
      63: return w(9'd66,  BR, 2'd1, 1'b0, ctl(63));
      64: return w(9'd64,  NX, 2'd0, 1'b0, ctl(64));
      66: return w(9'd66,  NX, 2'd0, 1'b0, ctl(66));
      75: return w(9'd75,  HT, 2'd0, 1'b0, ctl(75));
      default: return w(9'd0, NX, 2'd0, 1'b0, ctl(i));
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    chk("reset_load_upc", 64'(upc), 64'd0);
  endtask

  task automatic boot(input logic [8:0] v);
    do_reset;
    ir = v;
    tick; chk("boot_upc1", 64'(upc), 64'd1);
    tick; chk("boot_upc2", 64'(upc), 64'd2);
    tick; chk("boot_upc3", 64'(upc), 64'd3);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; prog_we = 1'b0; ir = '0; cond = '0;
    prog_addr = '0; prog_data = '0;
    tick; tick;
    chk("reset_upc",    64'(upc),     64'd0);
    chk("reset_mir",    64'(mir),     64'd0);
    chk("reset_halted", 64'(halted),  64'd0);
    chk("reset_err",    64'(seq_err), 64'd0);
    $display("reset state checked");

    rst_n = 1'b1;
    for (int i = 0; i < 76; i++) begin
      prog_we = 1'b1; prog_addr = 9'(i); prog_data = prog_word(i);
      tick;
    end
    prog_addr = 9'd76; prog_data = '1;
    tick;
    prog_we = 1'b0;
    chk("idle_upc", 64'(upc), 64'd0);
    chk("idle_mir", 64'(mir), 64'd0);
    $display("control store loaded");

    en = 1'b1; ir = 9'd5;
    tick; chk("first_upc", 64'(upc), 64'd0);
    chk("first_mir", 64'(mir), 64'(mm(9'd1, ctl(0))));
    tick; chk("next_upc1", 64'(upc), 64'd1);
    en = 1'b0;
    tick; tick;
    chk("hold_upc", 64'(upc), 64'd1);
    chk("hold_mir", 64'(mir), 64'(mm(9'd2, ctl(1))));
    en = 1'b1;
    tick; chk("next_upc2", 64'(upc), 64'd2);
    tick; chk("next_upc3", 64'(upc), 64'd3);
    tick; chk("disp5_upc", 64'(upc), 64'd5);
    chk("disp5_mir", 64'(mir), 64'(mm(9'd5, ctl(5))));
    $display("next chain and dispatch to 5: upc=%0d", upc);

    rst_n = 1'b0;
    #1;
    chk("midrst_upc", 64'(upc), 64'd0);
    chk("midrst_mir", 64'(mir), 64'd0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_rel_upc", 64'(upc), 64'd0);
    chk("rst_rel_mir", 64'(mir), 64'(mm(9'd1, ctl(0))));
    $display("mid-run reset: upc=%0d", upc);

    ir = 9'd20;
    tick; tick; tick;
    chk("disp20_pre", 64'(upc), 64'd3);
    tick; chk("disp20_upc", 64'(upc), 64'd20);
    tick; chk("to63_upc", 64'(upc), 64'd63);
    cond = 4'b1101;
    tick; chk("br_nt_upc", 64'(upc), 64'd64);
    chk("br_nt_mir", 64'(mir), 64'(mm(9'd64, ctl(64))));
    $display("branch not taken: upc=%0d", upc);

    cond = 4'b0010;
    boot(9'd63);
    tick; chk("br_at63", 64'(upc), 64'd63);
    tick; chk("br_t_upc", 64'(upc), 64'd66);
    cond = 4'b0000;
    $display("branch taken: upc=%0d", upc);

    boot(9'd13);
    tick; chk("sub_ir13", 64'(mir), 64'(mm(9'd13, 27'h7FFFF87)));
    ir = 9'd1; tick; chk("sub_ir1", 64'(mir), 64'(mm(9'd13, 27'h7FFFF9F)));
    ir = 9'd8; tick; chk("sub_ir8", 64'(mir), 64'(mm(9'd13, 27'h7FFFFD7)));
    ir = 9'd9; tick; chk("sub_ir9", 64'(mir), 64'(mm(9'd13, 27'h7FFFF87)));
    ir = 9'd4; tick; chk("sub_ir4", 64'(mir), 64'(mm(9'd13, 27'h7FFFFB7)));
    ir = 9'd0; tick; chk("sub_ir0", 64'(mir), 64'(mm(9'd13, 27'h7FFFF87)));
    $display("substitution sequence done");

    boot(9'd21);
    tick; chk("oor_at21", 64'(upc), 64'd21);
    tick; chk("oor_upc", 64'(upc), 64'd100);
    chk("oor_mir", 64'(mir), 64'd0);
    tick; chk("oor_back_upc", 64'(upc), 64'd0);
    chk("oor_back_mir", 64'(mir), 64'(mm(9'd1, ctl(0))));
    $display("next beyond depth: upc=%0d", upc);

    boot(9'd100);
    chk("bad_disp_err0", 64'(seq_err), 64'd0);
    tick; chk("bad_disp_upc", 64'(upc), 64'd0);
    chk("bad_disp_err", 64'(seq_err), 64'd1);
    chk("bad_disp_mir", 64'(mir), 64'(mm(9'd1, ctl(0))));
    tick; chk("err_sticky", 64'(seq_err), 64'd1);
    do_reset;
    chk("err_cleared", 64'(seq_err), 64'd0);
    $display("illegal dispatch: err flag checked");

    boot(9'd10);
    tick; chk("call_at10", 64'(upc), 64'd10);
    tick; chk("call_to40", 64'(upc), 64'd40);
    tick;
`ifdef MSEQ_CALL_STACK_EN
    chk("ret_upc", 64'(upc), 64'd11);
`else
    chk("ret_upc", 64'(upc), 64'd0);
`endif
    chk("ret_err", 64'(seq_err), 64'd0);
    $display("call/return: upc=%0d", upc);

    boot(9'd30);
    for (int i = 30; i <= 34; i++) begin
      tick; chk("nest_upc", 64'(upc), 64'(i));
    end
    chk("nest4_err", 64'(seq_err), 64'd0);
    tick; chk("nest5_upc", 64'(upc), 64'd35);
`ifdef MSEQ_CALL_STACK_EN
    chk("nest5_err", 64'(seq_err), 64'd1);
`else
    chk("nest5_err", 64'(seq_err), 64'd0);
`endif
    $display("nested calls: err=%0d", seq_err);

    boot(9'd40);
    tick; chk("empty_at40", 64'(upc), 64'd40);
    tick; chk("empty_ret_upc", 64'(upc), 64'd0);
`ifdef MSEQ_CALL_STACK_EN
    chk("empty_ret_err", 64'(seq_err), 64'd1);
`else
    chk("empty_ret_err", 64'(seq_err), 64'd0);
`endif
    $display("return on empty stack: upc=%0d", upc);

    boot(9'd75);
    prog_we = 1'b1; prog_addr = 9'd75; prog_data = w(9'd0, NX, 2'd0, 1'b0, 27'h0ABCDE);
    tick;
    prog_we = 1'b0;
    chk("halt_fetch_upc", 64'(upc), 64'd75);
    chk("rbw_mir", 64'(mir), 64'(mm(9'd75, ctl(75))));
    chk("halt_pre", 64'(halted), 64'd0);
    tick;
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_upc", 64'(upc), 64'd75);
    for (int i = 0; i < 9; i++) begin
      tick; chk("halt_hold_upc", 64'(upc), 64'd75);
    end
    chk("halt_hold_mir", 64'(mir), 64'(mm(9'd75, ctl(75))));
    chk("halt_hold_flag", 64'(halted), 64'd1);
    $display("halt: upc=%0d halted=%0d", upc, halted);

    boot(9'd75);
    chk("halt_rst_clear", 64'(halted), 64'd0);
    tick; chk("new75_upc", 64'(upc), 64'd75);
    chk("new75_mir", 64'(mir), 64'(mm(9'd0, 27'h0ABCDE)));
    tick; chk("new75_next", 64'(upc), 64'd0);
    chk("new75_nohalt", 64'(halted), 64'd0);
    $display("rewritten word 75: upc=%0d", upc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
